// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: holds the fetch PC, issues word-aligned reads to
// instruction memory, queues in-order responses and hands {instr, instr_pc}
// to decode. A redirect flushes the queue and discards responses that belong
// to requests issued before the redirect.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          QDEPTH   = 2
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc
);

    localparam int CW = $clog2(QDEPTH + 1);
    localparam int PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
    localparam logic [CW:0]   CREDIT = (CW + 1)'(QDEPTH);
    localparam logic [CW-1:0] FULL   = CW'(QDEPTH);

    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [31:0]   rsp_pc_q, rsp_pc_d;
    logic [CW-1:0] occ_q, occ_d;
    logic [CW-1:0] outst_q, outst_d;
    logic [CW-1:0] drop_q, drop_d;
    logic [PW-1:0] head_q, head_d;
    logic [PW-1:0] tail_q, tail_d;
    logic [31:0]   q_instr_q [QDEPTH];
    logic [31:0]   q_pc_q    [QDEPTH];

    logic        req_fire;
    logic        rsp_keep;
    logic        pop;
    logic [31:0] target_pc;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(QDEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    // Credit-based request issue and decode-side presentation of the queue head
    always_comb begin
        imem_req_valid = !reset && !redirect_valid &&
                         (({1'b0, occ_q} + {1'b0, outst_q}) < CREDIT);
        imem_req_addr  = fetch_pc_q;
        instr_valid    = !reset && !redirect_valid && (occ_q != '0);
        instr          = q_instr_q[head_q];
        instr_pc       = q_pc_q[head_q];
        req_fire       = imem_req_valid && imem_req_ready;
        pop            = instr_valid && instr_ready;
        // A response arriving in a redirect cycle belongs to the old stream.
        rsp_keep       = imem_rsp_valid && (drop_q == '0) && !redirect_valid;
        target_pc      = redirect_pc & ~32'h3;
    end

    // Next-state for PCs, counters and queue pointers; redirect overrides
    always_comb begin
        fetch_pc_d = fetch_pc_q;
        rsp_pc_d   = rsp_pc_q;
        head_d     = head_q;
        tail_d     = tail_q;
        drop_d     = drop_q;
        outst_d    = outst_q + CW'(req_fire) - CW'(imem_rsp_valid);
        occ_d      = occ_q + CW'(rsp_keep) - CW'(pop);
        if (req_fire) begin
            fetch_pc_d = fetch_pc_q + 32'd4;
        end
        if (imem_rsp_valid && (drop_q != '0)) begin
            drop_d = drop_q - CW'(1);
        end
        if (rsp_keep) begin
            tail_d   = ptr_inc(tail_q);
            rsp_pc_d = rsp_pc_q + 32'd4;
        end
        if (pop) begin
            head_d = ptr_inc(head_q);
        end
        if (redirect_valid) begin
            fetch_pc_d = target_pc;
            rsp_pc_d   = target_pc;
            occ_d      = '0;
            head_d     = '0;
            tail_d     = '0;
            // Every request still in flight after this edge is stale.
            drop_d     = outst_d;
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc_q <= RESET_PC;
            rsp_pc_q   <= RESET_PC;
            occ_q      <= '0;
            outst_q    <= '0;
            drop_q     <= '0;
            head_q     <= '0;
            tail_q     <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            rsp_pc_q   <= rsp_pc_d;
            occ_q      <= occ_d;
            outst_q    <= outst_d;
            drop_q     <= drop_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
        end
    end

    // Queue storage: write accepted response at the tail (no reset needed)
    always_ff @(posedge clk) begin
        if (rsp_keep) begin
            q_instr_q[tail_q] <= imem_rsp_data;
            q_pc_q[tail_q]    <= rsp_pc_q;
        end
    end

    // Memory must never answer without an outstanding request, and the
    // credit rule must keep room for every non-dropped response.
    a_rsp_has_req : assert property (@(posedge clk) disable iff (reset)
        imem_rsp_valid |-> (outst_q != '0));
    a_no_overflow : assert property (@(posedge clk) disable iff (reset)
        rsp_keep |-> (occ_q != FULL));

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Producer side of the instruction stream consumed by the main decoder.
- Holds the fetch PC and issues word-aligned read requests to instruction memory.
- Buffers in-order responses in a 2-entry queue and presents {instr, instr_pc} to decode over a valid/ready handshake.
- On a taken branch or jump redirect, flushes the queue and discards responses from stale in-flight requests.

Parameters:
- RESET_PC, 32'h0000_0000, fetch PC loaded on reset
- QDEPTH, 2, instruction queue depth; credit limit for outstanding requests plus queued entries

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- imem_req_valid  output  1  read request valid
- imem_req_ready  input  1  memory accepts request this cycle
- imem_req_addr  output  32  request byte address, bits [1:0] always 0
- imem_rsp_valid  input  1  read data valid; responses are in order, latency ≥1 cycle, cannot be stalled
- imem_rsp_data  input  32  instruction word
- instr_valid  output  1  queue head valid to decode
- instr_ready  input  1  decode accepts head
- instr  output  32  head instruction (op = instr[6:0])
- instr_pc  output  32  PC of head instruction
- redirect_valid  input  1  branch/jump taken, one-cycle pulse
- redirect_pc  input  32  new fetch target; bits [1:0] ignored (forced 0)

Behaviour:
- State:
  - fetch_pc: next request address.
  - rsp_pc: PC of the next non-dropped response.
  - occ (0..QDEPTH): queue occupancy.
  - outst (0..QDEPTH): accepted requests with no response yet.
  - drop (0..QDEPTH): stale responses still to discard.
- Reset, taking effect at the edge where reset=1:
  - fetch_pc = rsp_pc = RESET_PC; occ = outst = drop = 0.
  - imem_req_valid = 0 and instr_valid = 0 while reset is high.
- Request issue:
  - imem_req_valid = !reset && !redirect_valid && (occ + outst < QDEPTH).
  - imem_req_addr = fetch_pc.
  - On req_valid && req_ready: fetch_pc += 4 (wraps mod 2^32) and outst += 1.
- Response handling, on imem_rsp_valid (outst decrements every time):
  - If drop > 0: discard the data and decrement drop.
  - Else: push {imem_rsp_data, rsp_pc} at the queue tail and add 4 to rsp_pc.
  - The credit rule guarantees the queue is never full when a non-dropped response arrives. An assertion fires on overflow, or on rsp_valid with outst == 0.
- Decode handshake:
  - instr_valid = (occ > 0) && !redirect_valid.
  - instr and instr_pc come from the head register and are held stable while valid && !ready.
  - A pop occurs on instr_valid && instr_ready.
  - Push and pop in the same cycle are allowed; occ is unchanged.
- Latency:
  - The response edge writes the queue; instr_valid rises the following cycle.
  - Best-case request-to-decode is memory latency + 1 cycle.
- Redirect (redirect_valid = 1 in cycle t):
  - In cycle t, imem_req_valid = 0 and instr_valid = 0; no handshake completes.
  - At edge t:
    - occ = 0 (queue flushed).
    - fetch_pc = rsp_pc = {redirect_pc[31:2], 2'b00}.
    - drop = outst_next, where outst_next = outst - rsp_valid. A response arriving in cycle t belongs to the old stream and is discarded.
  - From t+1, fetch resumes at the new PC.
  - Back-to-back redirects: the last one wins; drop recomputes from current outst.
- Simultaneous reset and redirect: reset wins.
- Reset asserted mid-operation:
  - All state clears.
  - Memory must also be reset in the same cycle, so no responses arrive for pre-reset requests.

Test Plan:
- Reset with RESET_PC=0, memory latency 1, always ready, decode always ready:
  - Required: requests at 0x0, 0x4, 0x8, ….
  - Required: decode receives instr_pc 0x0, 0x4, 0x8 with matching words, at most 2 in flight.
- Decode stalled (instr_ready=0) for 10 cycles:
  - Required: occ saturates at 2, imem_req_valid drops to 0, and instr and instr_pc hold stable.
  - Release: the stream continues with no loss or duplication.
- Memory latency 3, redirect_pc=0x100 with 2 requests in flight:
  - Required: both stale responses are discarded.
  - Required: the next delivered instr_pc is 0x100, then 0x104.
- Redirect in the same cycle as a response and with instr_valid=1:
  - Required: instr_valid=0 that cycle and the response is dropped.
  - Required: drop = outst-1, and the first output after the redirect is the target PC.
- redirect_pc=0x203:
  - Required: imem_req_addr=0x200.
- Fetch from fetch_pc=0xFFFF_FFFC:
  - Required: the next request wraps to 0x0000_0000.
- Reset asserted mid-stream with the queue full:
  - Required: instr_valid=0 next cycle.
  - Required: first request after reset deasserts is at RESET_PC.
